// File: rtl/fpu_seq_ctrl.sv
// Sequencer between the pipeline and a multi-cycle FPALU: queues requests, issues one operation
// at a time, waits for completion with a timeout and returns registered results.
module fpu_seq_ctrl #(
    parameter int unsigned TIMEOUT     = 24,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        iclock,
    input  logic        ireset,

    input  logic        ireq,
    input  logic [4:0]  iop,
    input  logic [31:0] idataa,
    input  logic [31:0] idatab,
    output logic        oaccept,
    output logic        ostall,

    output logic        ofpu_start,
    output logic [4:0]  ofpu_control,
    output logic [31:0] ofpu_dataa,
    output logic [31:0] ofpu_datab,
    input  logic        ifpu_ready,
    input  logic [31:0] ifpu_result,
    input  logic [3:0]  ifpu_flags,

    output logic        odone,
    output logic [31:0] oresult,
    output logic [3:0]  oflags,
    output logic        otimeout
);

    localparam int unsigned PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned EW  = 5 + 32 + 32;

    localparam logic [PW-1:0]  PTR_LAST   = PW'(QUEUE_DEPTH - 1);
    localparam logic [CNW-1:0] COUNT_FULL = CNW'(QUEUE_DEPTH);
    localparam logic [TW-1:0]  CNT_MAX    = TW'(TIMEOUT);
    localparam logic [TW-1:0]  CNT_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StDone
    } state_e;

    state_e         state_q;
    logic [TW-1:0]  cnt_q;

    logic [EW-1:0]  q_mem [QUEUE_DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CNW-1:0] count_q;
    logic [CNW-1:0] count_d;

    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    assign oaccept = (count_q != COUNT_FULL);
    assign ostall  = (state_q != StIdle) || (count_q != '0);

    assign push = ireq && oaccept;
    // The head is only consumed on the way into START, from IDLE or straight out of DONE.
    assign pop  = ((state_q == StIdle) || (state_q == StDone)) && (count_q != '0);
    assign head = q_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iclock) begin
        if (push) begin
            q_mem[wr_ptr_q] <= {iop, idataa, idatab};
        end
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ofpu_start   <= 1'b0;
            ofpu_control <= '0;
            ofpu_dataa   <= '0;
            ofpu_datab   <= '0;
            odone        <= 1'b0;
            otimeout     <= 1'b0;
            oresult      <= '0;
            oflags       <= '0;
        end else begin
            ofpu_start <= 1'b0;
            odone      <= 1'b0;
            otimeout   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {ofpu_control, ofpu_dataa, ofpu_datab} <= head;
                        ofpu_start <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Ready wins over a timeout landing on the same cycle.
                    if (ifpu_ready) begin
                        oresult <= ifpu_result;
                        oflags  <= ifpu_flags;
                        odone   <= 1'b1;
                        state_q <= StDone;
                    end else if ((cnt_q == CNT_LAST) || (cnt_q == CNT_MAX)) begin
                        oresult  <= '0;
                        oflags   <= '0;
                        odone    <= 1'b1;
                        otimeout <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (pop) begin
                        {ofpu_control, ofpu_dataa, ofpu_datab} <= head;
                        ofpu_start <= 1'b1;
                        state_q    <= StStart;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
